// File: rtl/counter_multi.sv
// Multi-channel down-counting timer: per-channel one-shot/auto-reload period
// counters on a shared tick, with done pulses and a saturating reload tally.
//
// state  | meaning
// IDLE   | halted; count held, ticks ignored
// RUN    | decrementing on timer_tick
// PAUSED | pause held high; count frozen until pause drops
module counter_multi #(
   parameter int WIDTH    = 32,
   parameter int CHANNELS = 4,
   parameter int RCW      = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      timer_tick,
   input  logic [CHANNELS-1:0]       start,
   input  logic [CHANNELS-1:0]       stop,
   input  logic [CHANNELS-1:0]       pause,
   input  logic [CHANNELS-1:0]       mode,
   input  logic [CHANNELS*WIDTH-1:0] N,
   output logic [CHANNELS*WIDTH-1:0] count,
   output logic [CHANNELS-1:0]       zero,
   output logic [CHANNELS-1:0]       running,
   output logic [CHANNELS-1:0]       done,
   output logic [CHANNELS*RCW-1:0]   reloads
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2
   } state_t;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      state_t             state_q, state_d;
      logic [WIDTH-1:0]   count_q, count_d;
      logic [WIDTH-1:0]   period_q, period_d;
      logic               mode_q, mode_d;
      logic               done_q, done_d;
      logic [RCW-1:0]     reloads_q, reloads_d;
      logic [WIDTH-1:0]   n_i;

      assign n_i = N[i*WIDTH +: WIDTH];

      always_ff @(posedge clk) begin
         if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            period_q  <= '0;
            mode_q    <= 1'b0;
            done_q    <= 1'b0;
            reloads_q <= '0;
         end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            period_q  <= period_d;
            mode_q    <= mode_d;
            done_q    <= done_d;
            reloads_q <= reloads_d;
         end
      end

      // Priority: start, stop, pause, tick.
      always_comb begin
         state_d   = state_q;
         count_d   = count_q;
         period_d  = period_q;
         mode_d    = mode_q;
         done_d    = 1'b0;
         reloads_d = reloads_q;
         if (start[i]) begin
            count_d   = n_i;
            period_d  = n_i;
            mode_d    = mode[i];
            reloads_d = '0;
            state_d   = (n_i != '0) ? RUN : IDLE;
         end else if (stop[i] && (state_q != IDLE)) begin
            state_d = IDLE;
         end else begin
            unique case (state_q)
               RUN: begin
                  if (pause[i]) begin
                     state_d = PAUSED;
                  end else if (timer_tick) begin
                     if (count_q == WIDTH'(1)) begin
                        done_d = 1'b1;
                        if (mode_q) begin
                           count_d = period_q;
                           if (reloads_q != {RCW{1'b1}})
                              reloads_d = reloads_q + RCW'(1);
                        end else begin
                           count_d = '0;
                           state_d = IDLE;
                        end
                     end else if (count_q != '0) begin
                        count_d = count_q - WIDTH'(1);
                     end
                  end
               end
               PAUSED: begin
                  if (!pause[i])
                     state_d = RUN;
               end
               default: ;
            endcase
         end
      end

      assign count[i*WIDTH +: WIDTH] = count_q;
      assign reloads[i*RCW +: RCW]   = reloads_q;
      assign zero[i]                 = (count_q == '0);
      assign running[i]              = (state_q == RUN);
      assign done[i]                 = done_q;
   end

endmodule

// File: tb/tb_counter_multi.sv
// Directed bench for counter_multi (WIDTH=8, CHANNELS=4, RCW=2).
module tb_counter_multi;
   localparam int W  = 8;
   localparam int CH = 4;
   localparam int RC = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              timer_tick;
   logic [CH-1:0]     start, stop, pause, mode;
   logic [CH*W-1:0]   n_vec;
   logic [CH*W-1:0]   count;
   logic [CH-1:0]     zero, running, done;
   logic [CH*RC-1:0]  reloads;

   int n_checks = 0;
   int n_errors = 0;

   // reference state for the tick-driven sections
   int            m_cnt [CH];
   int            m_per [CH];
   logic          m_mode[CH];
   logic          m_run [CH];
   int            m_rl  [CH];
   logic [CH-1:0] exp_done;
   logic [CH-1:0] exp_run;

   counter_multi #(.WIDTH(W), .CHANNELS(CH), .RCW(RC)) dut (
      .clk(clk), .rst(rst), .timer_tick(timer_tick),
      .start(start), .stop(stop), .pause(pause), .mode(mode),
      .N(n_vec), .count(count), .zero(zero), .running(running),
      .done(done), .reloads(reloads)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] cnt_of(input int ch);
      return 32'(count[ch*W +: W]);
   endfunction

   function automatic logic [31:0] rl_of(input int ch);
      return 32'(reloads[ch*RC +: RC]);
   endfunction

   task automatic model_tick();
      exp_done = '0;
      for (int c = 0; c < CH; c++) begin
         if (m_run[c]) begin
            if (m_cnt[c] == 1) begin
               exp_done[c] = 1'b1;
               if (m_mode[c]) begin
                  m_cnt[c] = m_per[c];
                  if (m_rl[c] < 3) m_rl[c]++;
               end else begin
                  m_cnt[c] = 0;
                  m_run[c] = 1'b0;
               end
            end else begin
               m_cnt[c]--;
            end
         end
      end
      for (int c = 0; c < CH; c++) exp_run[c] = m_run[c];
   endtask

   initial begin
      rst = 1'b1; timer_tick = 1'b0;
      start = '0; stop = '0; pause = '0; mode = '0;
      n_vec = {8'd5, 8'd5, 8'd5, 8'd5};

      // reset with start/tick toggling
      start = 4'hF; timer_tick = 1'b1; cyc();
      start = 4'h0; timer_tick = 1'b0; cyc();
      check("rst_count",   32'(count),   32'h0);
      check("rst_zero",    32'(zero),    32'hF);
      check("rst_running", 32'(running), 32'h0);
      check("rst_done",    32'(done),    32'h0);
      check("rst_reloads", 32'(reloads), 32'h0);
      rst = 1'b0;

      // one-shot ch0 N=5, tick in start cycle ignored
      n_vec[0*W +: W] = 8'd5; mode = 4'b0000; start = 4'b0001; timer_tick = 1'b1;
      cyc();
      start = '0;
      check("os_load",    cnt_of(0), 32'd5);
      check("os_running", 32'(running[0]), 32'd1);
      check("os_nodone",  32'(done[0]), 32'd0);
      for (int k = 4; k >= 0; k--) begin
         cyc();
         check("os_count", cnt_of(0), 32'(k));
         check("os_done",  32'(done[0]), (k == 0) ? 32'd1 : 32'd0);
      end
      check("os_zero",    32'(zero[0]), 32'd1);
      check("os_stopped", 32'(running[0]), 32'd0);
      cyc(); cyc();
      check("os_hold",     cnt_of(0), 32'd0);
      check("os_done_end", 32'(done[0]), 32'd0);

      // auto-reload ch1 N=3, tick every second cycle; reloads saturate at 3
      timer_tick = 1'b0;
      n_vec[1*W +: W] = 8'd3; mode = 4'b0010; start = 4'b0010; cyc();
      start = '0;
      check("ar_load", cnt_of(1), 32'd3);
      for (int c = 0; c < CH; c++) begin
         m_cnt[c] = 0; m_per[c] = 0; m_mode[c] = 1'b0; m_run[c] = 1'b0; m_rl[c] = 0;
      end
      m_cnt[1] = 3; m_per[1] = 3; m_mode[1] = 1'b1; m_run[1] = 1'b1;
      for (int cy = 1; cy <= 24; cy++) begin
         timer_tick = cy[0];
         cyc();
         if (timer_tick) model_tick(); else exp_done = '0;
         check("ar_count",   cnt_of(1), 32'(m_cnt[1]));
         check("ar_done",    32'(done[1]), 32'(exp_done[1]));
         check("ar_reloads", rl_of(1), 32'(m_rl[1]));
      end
      check("ar_sat", rl_of(1), 32'd3);
      timer_tick = 1'b0; stop = 4'b0010; cyc(); stop = '0;
      check("ar_stop", 32'(running[1]), 32'd0);

      // pause / stop on ch2 N=10
      n_vec[2*W +: W] = 8'd10; mode = 4'b0000; start = 4'b0100; cyc();
      start = '0; timer_tick = 1'b1;
      cyc(); cyc();
      check("ps_run", cnt_of(2), 32'd8);
      pause = 4'b0100;
      for (int k = 0; k < 4; k++) begin
         cyc();
         check("ps_frozen", cnt_of(2), 32'd8);
         check("ps_notrun", 32'(running[2]), 32'd0);
      end
      pause = '0;
      cyc();
      check("ps_resume_cnt", cnt_of(2), 32'd8);
      check("ps_resume_run", 32'(running[2]), 32'd1);
      cyc(); cyc();
      check("ps_dec", cnt_of(2), 32'd6);
      stop = 4'b0100; cyc(); stop = '0;
      check("stop_count", cnt_of(2), 32'd6);
      check("stop_run",   32'(running[2]), 32'd0);
      check("stop_done",  32'(done[2]), 32'd0);
      cyc(); cyc();
      check("stop_hold",  cnt_of(2), 32'd6);
      check("stop_nodone", 32'(done[2]), 32'd0);

      // priorities on ch3
      n_vec[3*W +: W] = 8'd4; start = 4'b1000; timer_tick = 1'b1; cyc();
      start = '0; timer_tick = 1'b0;
      check("pri_start_tick", cnt_of(3), 32'd4);
      n_vec[3*W +: W] = 8'd0; start = 4'b1000; cyc();
      start = '0;
      check("pri_n0_zero", 32'(zero[3]), 32'd1);
      check("pri_n0_run",  32'(running[3]), 32'd0);
      check("pri_n0_done", 32'(done[3]), 32'd0);
      cyc();
      check("pri_n0_done2", 32'(done[3]), 32'd0);
      n_vec[3*W +: W] = 8'd4; start = 4'b1000; cyc();
      start = '0; stop = 4'b1000; pause = 4'b1000; timer_tick = 1'b1; cyc();
      stop = '0;
      check("pri_stop_pause_run", 32'(running[3]), 32'd0);
      check("pri_stop_pause_cnt", cnt_of(3), 32'd4);
      cyc();
      check("pri_idle_pause", 32'(running[3]), 32'd0);
      pause = '0; cyc();
      check("pri_idle_stays", 32'(running[3]), 32'd0);

      // independence: N=i+2, ch1/ch3 auto-reload, N changed mid-run
      n_vec = {8'd5, 8'd4, 8'd3, 8'd2}; mode = 4'b1010; start = 4'hF; timer_tick = 1'b1;
      cyc();
      start = '0;
      for (int c = 0; c < CH; c++) begin
         m_cnt[c] = c + 2; m_per[c] = c + 2; m_mode[c] = mode[c]; m_run[c] = 1'b1; m_rl[c] = 0;
         check("ind_load", cnt_of(c), 32'(c + 2));
      end
      check("ind_running", 32'(running), 32'hF);
      for (int cy = 1; cy <= 12; cy++) begin
         if (cy == 2) n_vec = 32'h07070707;
         cyc();
         model_tick();
         check("ind_done", 32'(done), 32'(exp_done));
         check("ind_run",  32'(running), 32'(exp_run));
         for (int c = 0; c < CH; c++) check("ind_count", cnt_of(c), 32'(m_cnt[c]));
      end
      check("ind_rl1", rl_of(1), 32'd3);
      check("ind_rl3", rl_of(3), 32'd2);

      // reset mid-operation
      rst = 1'b1; cyc(); rst = 1'b0; timer_tick = 1'b0;
      check("mrst_count",   32'(count),   32'h0);
      check("mrst_running", 32'(running), 32'h0);
      check("mrst_done",    32'(done),    32'h0);
      check("mrst_reloads", 32'(reloads), 32'h0);
      check("mrst_zero",    32'(zero),    32'hF);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/counter_multi.md
# counter_multi

Parametrised multi-channel down-counting timer, successor to the single-channel start/tick counter. Each of CHANNELS independent channels loads a WIDTH-bit period, decrements on a shared timer tick, and signals expiry with a one-cycle done pulse. It adds per-channel one-shot/auto-reload mode, stop, pause, a registered count readout and a saturating reload counter. It sits between the register bank (periods, controls) and the trigger/sequencing logic that consumes the done pulses.

## Interface
- WIDTH, 32, counter and period width in bits (>=2)
- CHANNELS, 4, number of independent channels (>=1)
- RCW, 8, width of the per-channel reload counter
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- timer_tick  in  1  shared count enable; one decrement per channel per high cycle
- start  in  CHANNELS  per-channel load-and-run strobe
- stop  in  CHANNELS  per-channel halt strobe
- pause  in  CHANNELS  per-channel level; high suppresses decrements
- mode  in  CHANNELS  0 = one-shot, 1 = auto-reload; sampled at start
- N  in  CHANNELS*WIDTH  periods, channel i at bits [i*WIDTH +: WIDTH]
- count  out  CHANNELS*WIDTH  current counter values, same packing
- zero  out  CHANNELS  count of channel i equals 0
- running  out  CHANNELS  channel in RUN state
- done  out  CHANNELS  one-cycle expiry pulse
- reloads  out  CHANNELS*RCW  saturating count of auto-reload expiries

## Operation
- Per-channel FSM: IDLE, RUN, PAUSED. Channels fully independent; only timer_tick is shared.
- Per-channel registers: count, reload value (period), mode_l, state, done, reloads.
- Priority per channel, highest first: rst, start, stop, pause, tick.
- start[i] (any state): count <= N_i, period <= N_i, mode_l <= mode[i], reloads <= 0. Next state RUN if N_i != 0, else IDLE (no done pulse). Tick in the same cycle is ignored.
- stop[i] (RUN or PAUSED): state <= IDLE, count held (not cleared), no done. In IDLE: no effect.
- RUN with pause[i]=1: state <= PAUSED, count held. PAUSED with pause[i]=0: state <= RUN; decrementing resumes on the first tick where the state is RUN. Ticks in the transition cycle are ignored.
- RUN, pause[i]=0, timer_tick=1:
  - count > 1: count <= count-1.
  - count == 1, mode_l=0: count <= 0, state <= IDLE, done <= 1.
  - count == 1, mode_l=1: count <= period, state stays RUN, done <= 1, reloads <= reloads+1 saturating at 2^RCW-1.
- Auto-reload period: exactly period ticks between successive done pulses. Changing N mid-run has no effect until the next start.
- IDLE or PAUSED: ticks ignored, count held.
- No wrap-around: count never decrements below 0.
- Outputs: zero = (count == 0) and running = (state == RUN) are combinational from registers. count, done and reloads are registers.

## Timing
- Reset values: count = 0, zero = all 1, running = 0, done = 0, reloads = 0, state = IDLE, period = 0, mode_l = 0.
- start asserted in cycle k: count = N_i and running = 1 visible in cycle k+1.
- Expiring tick in cycle k: done = 1 in cycle k+1 only, deasserted in k+2 unless another expiry occurs. One-shot: zero = 1 and running = 0 in k+1.
- Tick-to-count latency is one cycle. In RUN with ticks every cycle, period P gives done every P cycles.
- rst mid-operation: all channels return to reset values the next cycle; pending done is lost.
- done is never asserted in the cycle immediately after a start.

## Test plan
- Reset: assert rst 2 cycles with start/tick toggling -> count=0, zero=all 1, running=0, done=0, reloads=0.
- One-shot: ch0 N=5, mode=0, start, tick every cycle -> count 5,4,3,2,1,0; single done pulse on the cycle count becomes 0; running drops then; further ticks leave count=0.
- Auto-reload: ch1 N=3, mode=1, tick every 2nd cycle -> done every 6 cycles; count cycles 3,2,1,3...; reloads reads 1,2,3...; with RCW=2 it saturates at 3.
- Pause/stop: ch2 N=10 running, pause high for 4 ticks -> count frozen, running=0; release -> resumes from frozen value. stop at count=6 -> IDLE, count stays 6, no done.
- Priorities: start and tick in the same cycle with N=4 -> count=4, not 3. start with N=0 -> IDLE, zero=1, no done. stop and pause together -> IDLE.
- Independence: all CHANNELS started with N=i+2, mixed modes -> each done pattern matches its own period with no cross-channel interaction; changing N mid-run leaves active periods unchanged.
